// File: rtl/wb_led_pwm_if.sv
// Pipelined Wishbone bus bundle (32-bit data, byte selects) shared by
// the SoC masters and the LED PWM peripheral.
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, wdata, sel,
        input  rdata, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, wdata, sel,
        output rdata, ack, err, stall
    );
endinterface

// File: rtl/wb_led_pwm.sv
// Wishbone LED controller: per-channel shadowed PWM duty on a shared prescaled counter.
// Define WB_LED_PWM_BLINK_EN to build the BLINK register, period counter and blink phase.
module wb_led_pwm #(
    parameter int unsigned size     = 'h1000,
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    wb_if.slave                 wb,
    output logic [NUM_LEDS-1:0] led
);
    localparam int AW = $clog2(size);
    localparam int IW = AW - 2;

    function automatic logic [31:0] merge_sel(input logic [31:0] cur,
                                              input logic [31:0] nw,
                                              input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : cur[b*8 +: 8];
        end
        return res;
    endfunction

    logic [IW-1:0]       idx;
    logic                acc;
    logic                mapped;
    logic                hit_ctrl;
    logic                hit_presc;
    logic                hit_status;
    logic                hit_blink;
    logic [NUM_LEDS-1:0] hit_duty;
    logic [31:0]         rd_val;
    logic [31:0]         wr_val;

    logic [NUM_LEDS-1:0] ctrl;
    logic [15:0]         presc;
    logic [15:0]         pc;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] pend [NUM_LEDS];
    logic [PWM_BITS-1:0] act  [NUM_LEDS];
    logic                presc_wr;
    logic                tick;
    logic                wrap;

    logic [NUM_LEDS-1:0] blink_mask;
    logic [15:0]         half;
    logic                phase;

    logic                ack_p1;
    logic                err_p1;
    logic [31:0]         rdata_p1;

    logic                unused_bits;

    assign idx = wb.adr[AW-1:2];
    assign acc = wb.cyc & wb.stb;
    assign unused_bits = ^{wb.adr[31:AW], wb.adr[1:0], wr_val};

    always_comb begin
        hit_ctrl   = (idx == IW'(0));
        hit_presc  = (idx == IW'(1));
        hit_status = (idx == IW'(2));
`ifdef WB_LED_PWM_BLINK_EN
        hit_blink  = (idx == IW'(3));
`else
        hit_blink  = 1'b0;
`endif
        for (int i = 0; i < NUM_LEDS; i++) begin
            hit_duty[i] = (idx == IW'(4 + i));
        end
        mapped = hit_ctrl | hit_presc | hit_status | hit_blink | (|hit_duty);

        rd_val = '0;
        if (hit_ctrl)   rd_val[NUM_LEDS-1:0] = ctrl;
        if (hit_presc)  rd_val[15:0] = presc;
        if (hit_status) begin
            rd_val[PWM_BITS-1:0] = cnt;
            rd_val[31]           = phase;
        end
        if (hit_blink) begin
            rd_val[NUM_LEDS-1:0] = blink_mask;
            rd_val[31:16]        = half;
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (hit_duty[i]) rd_val[PWM_BITS-1:0] = pend[i];
        end

        // Readback of a writable register is its zero-extended value, so it
        // doubles as the merge base for byte-select writes.
        wr_val = merge_sel(rd_val, wb.wdata, wb.sel);
    end

    // Bus response stage: ack/err/read data one clock after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
            ctrl     <= '0;
            presc    <= '0;
            for (int i = 0; i < NUM_LEDS; i++) pend[i] <= '0;
        end else begin
            ack_p1   <= acc & mapped;
            err_p1   <= acc & ~mapped;
            rdata_p1 <= (acc & ~wb.we) ? rd_val : '0;
            if (acc & wb.we) begin
                if (hit_ctrl)  ctrl  <= wr_val[NUM_LEDS-1:0];
                if (hit_presc) presc <= wr_val[15:0];
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (hit_duty[i]) pend[i] <= wr_val[PWM_BITS-1:0];
                end
            end
        end
    end

    assign wb.ack   = ack_p1;
    assign wb.err   = err_p1;
    assign wb.rdata = rdata_p1;
    assign wb.stall = 1'b0;

    // A PRESC write restarts the prescaler and swallows a coincident tick.
    assign presc_wr = acc & wb.we & hit_presc;
    assign tick     = (pc == presc) & ~presc_wr;
    assign wrap     = tick & (cnt == '1);

    // PWM stage: counters, shadow load at period start, registered LED drive
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            cnt <= '0;
            led <= '0;
            for (int i = 0; i < NUM_LEDS; i++) act[i] <= '0;
        end else begin
            pc <= (presc_wr || (pc == presc)) ? 16'd0 : pc + 16'd1;
            if (tick) cnt <= cnt + PWM_BITS'(1);
            if (wrap) begin
                for (int i = 0; i < NUM_LEDS; i++) act[i] <= pend[i];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                led[i] <= ctrl[i] & (cnt < act[i]) & ~(blink_mask[i] & phase);
            end
        end
    end

`ifdef WB_LED_PWM_BLINK_EN
    logic [15:0] pcnt;

    // Blink stage: phase flips after HALF+1 completed PWM periods
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_mask <= '0;
            half       <= '0;
            pcnt       <= '0;
            phase      <= 1'b0;
        end else if (acc & wb.we & hit_blink) begin
            blink_mask <= wr_val[NUM_LEDS-1:0];
            half       <= wr_val[31:16];
            pcnt       <= '0;
            phase      <= 1'b0;
        end else if (wrap) begin
            if (pcnt == half) begin
                pcnt  <= '0;
                phase <= ~phase;
            end else begin
                pcnt <= pcnt + 16'd1;
            end
        end
    end
`else
    assign blink_mask = '0;
    assign half       = '0;
    assign phase      = 1'b0;
`endif

endmodule
